// File: rtl/mem_c_deskew.sv
// mem_c_deskew
// Result-side collector for the systolic matrix multiplier. The array emits
// one result row per cycle, and lane x lags lane 0 by x cycles. Each lane is
// realigned by a short delay line. While collecting, the block then writes
// DEPTH aligned rows into a result buffer. The controller reads that buffer
// back one element at a time through a registered row/col port.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   en        pipeline advance (delay lines, valid pipe, row capture)
//   start     one-cycle pulse: IDLE -> COLLECT
//   clear     one-cycle pulse: releases FULL or aborts COLLECT (wins over start)
//   valid_in  a row enters on lane 0 this cycle
//   Cin       DEPTH lanes of BITS_C signed accumulators, lane x lags x cycles
//   rd_en     read request
//   rd_row    read row address
//   rd_col    read column address
//   Cout      registered read data (signed BITS_OUT)
//   rd_valid  Cout answers the request made on the previous cycle
//   busy      high while collecting
//   done      high while the buffer holds DEPTH captured rows
//
// Configuration macro
//   MEMC_SAT_EN  defined:   stored values saturate to the BITS_OUT signed range
//                undefined: stored values keep the low BITS_OUT bits (wrap)
module mem_c_deskew #(
  parameter  int BITS_C   = 16,
  parameter  int BITS_OUT = 16,
  parameter  int DEPTH    = 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           start,
  input  logic                           clear,
  input  logic                           valid_in,
  input  logic [DEPTH-1:0][BITS_C-1:0]   Cin,
  input  logic                           rd_en,
  input  logic [AW-1:0]                  rd_row,
  input  logic [AW-1:0]                  rd_col,
  output logic signed [BITS_OUT-1:0]     Cout,
  output logic                           rd_valid,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t                       state;
  logic [AW-1:0]                wr_row;
  logic [DEPTH-1:0][BITS_C-1:0] aligned;
  logic [DEPTH-2:0]             vpipe;
  logic                         valid_al;
  logic                         row_wr;
  logic signed [BITS_OUT-1:0]   mem [DEPTH][DEPTH];

  // ---------------------------------------------------------------------------
  // Narrowing at the buffer write.
  // ---------------------------------------------------------------------------
`ifdef MEMC_SAT_EN
  localparam logic signed [BITS_C-1:0] SAT_HI = BITS_C'((64'sd1 <<< (BITS_OUT-1)) - 64'sd1);
  localparam logic signed [BITS_C-1:0] SAT_LO = -SAT_HI - BITS_C'(1);

  function automatic logic [BITS_OUT-1:0] narrow(input logic signed [BITS_C-1:0] v);
    if (v > SAT_HI)      return SAT_HI[BITS_OUT-1:0];
    else if (v < SAT_LO) return SAT_LO[BITS_OUT-1:0];
    else                 return v[BITS_OUT-1:0];
  endfunction
`else
  function automatic logic [BITS_OUT-1:0] narrow(input logic [BITS_C-1:0] v);
    return v[BITS_OUT-1:0];
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Per-lane de-skew: lane x is delayed by DEPTH-1-x en-cycles, so all lanes
  // of one row line up with the last lane, which passes straight through.
  // ---------------------------------------------------------------------------
  for (genvar x = 0; x < DEPTH; x++) begin : g_lane
    localparam int N = DEPTH - 1 - x;
    if (N == 0) begin : g_pass
      assign aligned[x] = Cin[x];
    end else begin : g_dly
      logic [BITS_C-1:0] dl [N];
      always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // stage samples its neighbour's pre-edge value; blocking here would
        // collapse the shift chain into a single stage.
        if (rst) begin
          for (int i = 0; i < N; i++) dl[i] <= '0;
        end else if (en) begin
          dl[0] <= Cin[x];
          for (int i = 1; i < N; i++) dl[i] <= dl[i-1];
        end
      end
      assign aligned[x] = dl[N-1];
    end
  end

  // valid_in travels the same DEPTH-1 en-cycles as lane 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe <= '0;
    end else if (en) begin
      vpipe[0] <= valid_in;
      for (int i = 1; i < DEPTH - 1; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  assign valid_al = vpipe[DEPTH-2];
  assign row_wr   = valid_al && en;

  // ---------------------------------------------------------------------------
  // Collection FSM and result buffer. busy/done are registered alongside the
  // state so they change on the same edge as the state itself.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      wr_row <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      // NOTE: the buffer is reset entry by entry because read-back after reset
      // must return 0; this keeps it in flops rather than a RAM macro.
      for (int r = 0; r < DEPTH; r++)
        for (int c = 0; c < DEPTH; c++)
          mem[r][c] <= '0;
    end else if (clear) begin
      // clear dominates start and also suppresses a coincident row write.
      state  <= S_IDLE;
      wr_row <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_COLLECT;
            wr_row <= '0;
            busy   <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (row_wr) begin
            for (int c = 0; c < DEPTH; c++)
              mem[wr_row][c] <= narrow(aligned[c]);
            if (wr_row == AW'(DEPTH - 1)) begin
              state  <= S_FULL;
              wr_row <= '0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              wr_row <= wr_row + AW'(1);
            end
          end
        end
        S_FULL: begin
          // Hold until clear; aligned rows and start are ignored here.
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read port, independent of en and state. A same-cycle write to
  // the addressed row is not visible yet, so the old value is returned.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      Cout     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) Cout <= mem[rd_row][rd_col];
    end
  end

endmodule

// File: tb/tb_mem_c_deskew.sv
// tb_mem_c_deskew
// Self-checking bench for mem_c_deskew with DEPTH=4, BITS_C=16, BITS_OUT=8.
// Skewed rows are driven from a source table. The expected buffer holds the
// rows, narrowed arithmetically according to MEMC_SAT_EN. The expected done
// timing comes from the latency rule (2*DEPTH cycles plus any en stalls).
module tb_mem_c_deskew;

  localparam int D  = 4;
  localparam int BC = 16;
  localparam int BO = 8;

  logic                    clk = 1'b0;
  logic                    rst, en, start, clear, valid_in;
  logic [D-1:0][BC-1:0]    cin;
  logic                    rd_en;
  logic [1:0]              rd_row, rd_col;
  logic signed [BO-1:0]    cout;
  logic                    rd_valid, busy, done;

  int nvec = 0;
  int nerr = 0;

  int src  [8][D];   // rows to stream (row, lane)
  int expb [D][D];   // expected buffer contents

  typedef struct {
    int in_val;
    int exp_wrap;
    int exp_sat;
  } nvec_t;

  mem_c_deskew #(.BITS_C(BC), .BITS_OUT(BO), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .clear    (clear),
    .valid_in (valid_in),
    .Cin      (cin),
    .rd_en    (rd_en),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .Cout     (cout),
    .rd_valid (rd_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    nvec++;
    if (actual !== expected) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Value actually stored for an input v, from the range rules alone.
  function automatic int model_narrow(input int v);
    int lo, hi, m;
    hi = (1 << (BO - 1)) - 1;
    lo = -(1 << (BO - 1));
`ifdef MEMC_SAT_EN
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    m = ((v % (1 << BO)) + (1 << BO)) % (1 << BO);
    return (m > hi) ? m - (1 << BO) : m;
`endif
  endfunction

  task automatic expect_src();
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        expb[r][c] = model_narrow(src[r][c]);
  endtask

  // Streams nrows skewed rows from src. An optional start pulse goes first.
  // Before en-cycle stall_at, stall_len en=0 cycles of garbage are inserted.
  // Returns the step count (start cycle = step 1) at which done was first seen.
  task automatic run_stream(input bit do_start, input int nrows, input int stall_at,
                            input int stall_len, output int done_step);
    int k, n, stalled, r;
    done_step = -1;
    n = 0;
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
      n = 1;
      if (done && done_step < 0) done_step = n;
    end
    k = 0;
    stalled = 0;
    while (n < 30) begin
      if (k == stall_at && stalled < stall_len) begin
        en       = 1'b0;
        valid_in = 1'($urandom);
        for (int x = 0; x < D; x++) cin[x] = BC'($urandom);
        stalled++;
      end else begin
        en       = 1'b1;
        valid_in = (k < nrows);
        for (int x = 0; x < D; x++) begin
          r = k - x;
          cin[x] = (r >= 0 && r < nrows) ? BC'(src[r][x]) : BC'($urandom);
        end
        k++;
      end
      step();
      n++;
      if (done && done_step < 0) done_step = n;
    end
    en       = 1'b1;
    valid_in = 1'b0;
  endtask

  task automatic read_one(input int r, input int c, input int exp_val, input string name);
    rd_en  = 1'b1;
    rd_row = 2'(r);
    rd_col = 2'(c);
    step();
    rd_en = 1'b0;
    check({name, "_rd_valid"}, int'(rd_valid), 1);
    check($sformatf("%s_r%0dc%0d", name, r, c), int'(cout), exp_val);
  endtask

  task automatic read_all(input string name);
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        read_one(r, c, expb[r][c], name);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    nvec_t tbl [16];
    int    ds;
    int    sa, sl;
    int    held;

    tbl = '{
      '{300,    44,  127}, '{-200,   56, -128}, '{127,   127,  127}, '{-128, -128, -128},
      '{128,  -128,  127}, '{-129,  127, -128}, '{0,       0,    0}, '{-1,     -1,   -1},
      '{255,    -1,  127}, '{256,     0,  127}, '{-256,    0, -128}, '{32767,  -1,  127},
      '{-32768,  0, -128}, '{1000,  -24,  127}, '{200,   -56,  127}, '{5,       5,    5}
    };

    rst = 1'b1; en = 1'b0; start = 1'b0; clear = 1'b0; valid_in = 1'b0;
    cin = '0; rd_en = 1'b0; rd_row = '0; rd_col = '0;
    step(); step();
    check("reset_busy",     int'(busy),     0);
    check("reset_done",     int'(done),     0);
    check("reset_rd_valid", int'(rd_valid), 0);
    check("reset_cout",     int'(cout),     0);
    rst = 1'b0;
    read_one(2, 3, 0, "reset_buf");

    // Basic collection: 10*r+c, en held high, done at start+2*D.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < D; c++)
        src[r][c] = 10 * r + c;
    expect_src();
    run_stream(1'b1, D, 99, 0, ds);
    check("basic_done_step", ds, 2 * D);
    check("basic_busy_after", int'(busy), 0);
    read_all("basic");
    step();
    check("idle_rd_valid", int'(rd_valid), 0);
    check("idle_cout_hold", int'(cout), expb[D-1][D-1]);

    // A fifth row plus a start pulse while FULL: ignored, done stays 1.
    for (int c = 0; c < D; c++) src[0][c] = 900 + c;
    run_stream(1'b1, 1, 99, 0, ds);
    check("full_done_held", int'(done), 1);
    check("full_busy", int'(busy), 0);
    read_all("full_unchanged");

    // clear together with start: clear wins, back to IDLE.
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    check("clear_done", int'(done), 0);
    check("clear_busy", int'(busy), 0);

    // Rows sent in IDLE are discarded.
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        src[r][c] = -50 - r * D - c;
    run_stream(1'b0, D, 99, 0, ds);
    check("idle_done", int'(done), 0);
    read_all("idle_unchanged");

    // Same basic stream, but en low for 3 cycles mid-stream: done 3 cycles later.
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        src[r][c] = 10 * r + c;
    expect_src();
    run_stream(1'b1, D, 3, 3, ds);
    check("stall_done_step", ds, 2 * D + 3);
    read_all("stall");
    pulse_clear();

    // Abort after two captured rows, then a fresh collection.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < D; c++)
        src[r][c] = 77;
    run_stream(1'b1, 2, 99, 0, ds);
    check("abort_busy_before", int'(busy), 1);
    pulse_clear();
    check("abort_busy_after", int'(busy), 0);
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        src[r][c] = 100 + 10 * r + c;
    expect_src();
    run_stream(1'b1, D, 99, 0, ds);
    check("abort_done_step", ds, 2 * D);
    read_all("after_abort");
    pulse_clear();

    // Narrowing table: 16 values loaded as one 4x4 block.
    for (int i = 0; i < 16; i++) src[i / D][i % D] = tbl[i].in_val;
    run_stream(1'b1, D, 99, 0, ds);
    check("narrow_done_step", ds, 2 * D);
    for (int i = 0; i < 16; i++) begin
`ifdef MEMC_SAT_EN
      read_one(i / D, i % D, tbl[i].exp_sat, "narrow");
`else
      read_one(i / D, i % D, tbl[i].exp_wrap, "narrow");
`endif
    end
    pulse_clear();

    // Randomized collections with a random stall, against the arithmetic model.
    for (int it = 0; it < 4; it++) begin
      for (int r = 0; r < D; r++)
        for (int c = 0; c < D; c++)
          src[r][c] = int'($urandom_range(0, 65535)) - 32768;
      expect_src();
      sa = int'($urandom_range(1, 6));
      sl = int'($urandom_range(0, 3));
      run_stream(1'b1, D, sa, sl, ds);
      check($sformatf("rand%0d_done_step", it), ds, 2 * D + sl);
      read_all($sformatf("rand%0d", it));
      pulse_clear();
    end

    // Reset in the middle of a collection.
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        src[r][c] = 1 + r + c;
    start = 1'b1;
    step();
    start = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      valid_in = 1'b1;
      for (int x = 0; x < D; x++) cin[x] = BC'(src[0][x]);
      step();
    end
    valid_in = 1'b0;
    rd_en  = 1'b1;
    rd_row = 2'd1;
    rd_col = 2'd1;
    step();
    held = int'(cout);
    rst = 1'b1;
    step();
    rst   = 1'b0;
    rd_en = 1'b0;
    check("rst_busy",     int'(busy),     0);
    check("rst_done",     int'(done),     0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_cout",     int'(cout),     0);
    read_one(1, 1, 0, "rst_buf");
    if (held != 0) check("rst_prior_read_nonzero", held, held);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_c_deskew.md
# mem_c_deskew

Result-side collector for the systolic matrix multiplier: the counterpart to the staggered B loader. The array emits one result row per cycle, skewed so that lane x lags lane 0 by x cycles. This block de-skews the lanes with per-lane delay lines and captures DEPTH aligned rows into a result buffer. The controller then reads the buffer element by element through a registered row/col port.

## Interface
- BITS_C, 16: width of each incoming accumulator value (signed).
- BITS_OUT, 16: width of each stored and read-back value (signed); BITS_OUT <= BITS_C.
- DEPTH, 8: array dimension; number of lanes and number of rows captured.
- clk  in  1  the single clock; all state is updated on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  pipeline advance; delay lines, the valid pipe and row capture move only when en=1.
- start  in  1  one-cycle pulse that arms collection.
- clear  in  1  one-cycle pulse that releases the buffer or aborts collection.
- valid_in  in  1  marks a row entering on lane 0 this cycle.
- Cin  in  DEPTH x BITS_C  lane x carries column x, lagging lane 0 by x en-cycles.
- rd_en  in  1  read request.
- rd_row, rd_col  in  $clog2(DEPTH) each  read address.
- Cout  out  BITS_OUT  read data, signed.
- rd_valid  out  1  Cout holds data for the request made on the previous cycle.
- busy  out  1  high in COLLECT.
- done  out  1  high in FULL.

## Operation
- De-skew: lane x passes through DEPTH-1-x en-gated registers. Lane DEPTH-1 is combinational pass-through. valid_in passes through DEPTH-1 en-gated registers to form valid_al.
- An aligned row appears on the cycle where valid_al=1 and en=1.
- FSM IDLE -> COLLECT on start. COLLECT -> FULL on the write of row DEPTH-1. FULL -> IDLE on clear. COLLECT -> IDLE on clear (abort).
- In COLLECT, each aligned row is written to buffer[wr_row] and wr_row increments. wr_row resets to 0 when entering COLLECT and on clear.
- Aligned rows in IDLE or FULL are discarded; the buffer is unchanged.
- start while in COLLECT or FULL is ignored.
- If clear and start arrive together, clear wins and the state becomes IDLE.
- Reads are legal in any state and do not depend on en. A read of the row being written in the same cycle returns the old value.
- Narrowing from BITS_C to BITS_OUT is applied at the buffer write; see Configuration.

## Timing
- Reset values: state=IDLE, wr_row=0, busy=0, done=0, rd_valid=0, Cout=0. All delay-line registers, the valid pipe and every buffer entry are cleared to 0.
- Latency: a row whose lane-0 element enters at en-cycle t is written at en-cycle t+DEPTH-1. done rises the cycle after the last row is written.
- With back-to-back valid rows and en held high, start at cycle s and first valid_in at s+1 give done=1 at cycle s+2*DEPTH.
- Read: rd_en sampled at cycle n produces Cout = buffer[rd_row][rd_col] and rd_valid=1 at n+1. When rd_en=0, rd_valid=0 and Cout holds its last value.
- When en=0, delay lines, the valid pipe and wr_row are frozen; no pipeline content is lost.
- Reset asserted mid-collection returns every output to its reset value on the next edge.

## Configuration
- MEMC_SAT_EN defined: stored values clamp to [-2^(BITS_OUT-1), 2^(BITS_OUT-1)-1].
- MEMC_SAT_EN undefined: stored values keep the low BITS_OUT bits (two's-complement wrap).
- When BITS_OUT=BITS_C, both builds behave identically.

## Test plan
- DEPTH=4, start, then four skewed rows with row r, col c = 10*r+c fed at en=1 -> done=1 at start+8; reading every (r,c) returns 10*r+c with rd_valid one cycle after rd_en.
- The same stream with en deasserted for 3 cycles mid-stream -> identical buffer contents; done is delayed by exactly 3 cycles.
- Rows sent in IDLE, plus a fifth row sent after FULL -> buffer unchanged, done stays 1; clear -> done=0, busy=0.
- clear asserted after two rows are captured, then start and four new rows -> buffer holds only the new rows.
- BITS_C=16, BITS_OUT=8, input 300 and -200 -> 127 and -128 with MEMC_SAT_EN; 44 and 56 without.
- rst pulse during COLLECT -> next cycle busy=0, done=0, rd_valid=0; a read of (1,1) returns 0.
